// File: rtl/apb_requester.sv
// APB3 requester: single-beat command in, response strobe 3 cycles after accept (+1 per wait state).
// No response backpressure; cmd_ready drops while busy. `APB_REQUESTER_TIMEOUT_EN adds an ACCESS-phase abort.
module apb_requester #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int TIMEOUT   = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [DATA_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_slverr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDR_SIZE-1:0] paddr,
  output logic [DATA_SIZE-1:0] pwdata,
  input  logic                 pready,
  input  logic [DATA_SIZE-1:0] prdata,
  input  logic                 pslverr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_done;
  logic                   w_timeout;
  logic                   w_psel_nxt;
  logic                   w_penable_nxt;
  logic                   w_cmd_ready_nxt;
  logic                   w_rsp_valid_nxt;

  logic                   r_cmd_ready;
  logic                   r_psel;
  logic                   r_penable;
  logic                   r_pwrite;
  logic [ADDR_SIZE-1:0]   r_paddr;
  logic [DATA_SIZE-1:0]   r_pwdata;
  logic                   r_rsp_valid;
  logic [DATA_SIZE-1:0]   r_rsp_rdata;
  logic                   r_rsp_slverr;

  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_done   = (r_state == S_ACCESS) & pready;

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts stalled ACCESS cycles; holding it at zero outside ACCESS clears it on entry.
  always_ff @(posedge pclk) begin
    if (preset || (r_state != S_ACCESS)) begin
      r_tmo_cnt <= '0;
    end else if (!pready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_ACCESS) & ~pready & (r_tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that every port comes straight from a flop.
  always_comb begin
    w_psel_nxt      = (w_state_nxt != S_IDLE);
    w_penable_nxt   = (w_state_nxt == S_ACCESS);
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_rsp_valid_nxt = w_done | w_timeout;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cmd_ready  <= 1'b1;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      if (w_accept) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
      end
      if (w_done) begin
        r_rsp_rdata  <= r_pwrite ? '0 : prdata;
        r_rsp_slverr <= pslverr;
      end else if (w_timeout) begin
        r_rsp_rdata  <= '0;
        r_rsp_slverr <= 1'b1;
      end
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_slverr = r_rsp_slverr;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: transfer-level reference model checked every cycle, plus directed literal checks.
module tb_apb_requester;
  localparam int DW         = 32;
  localparam int AW         = 10;
  localparam int TB_TIMEOUT = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  apb_requester #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT(TB_TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transfer is "busy" from accept until the first ACCESS cycle with pready
  // (or the stall limit); the first busy cycle is SETUP, all later ones are ACCESS.
  bit            m_on = 0, m_busy = 0, m_access = 0, m_rsp = 0, m_write = 0, m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  int            m_stall = 0;

  always @(posedge pclk) begin
    cyc++;
    if (preset) begin
      m_on = 1; m_busy = 0; m_access = 0; m_rsp = 0; m_write = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_stall = 0;
    end else if (m_on) begin
      m_rsp = 0;
      if (!m_busy) begin
        if (cmd_valid) begin
          m_busy = 1; m_access = 0; m_stall = 0;
          m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
        end
      end else if (!m_access) begin
        m_access = 1;
      end else if (pready) begin
        m_busy = 0; m_rsp = 1; m_err = pslverr;
        m_rdata = m_write ? '0 : prdata;
      end else begin
        m_stall++;
`ifdef APB_REQUESTER_TIMEOUT_EN
        if (m_stall == TB_TIMEOUT) begin
          m_busy = 0; m_rsp = 1; m_err = 1; m_rdata = '0;
        end
`endif
      end
    end
  end

  always @(negedge pclk) begin
    if (m_on) begin
      chk("cmd_ready",  cmd_ready,  !m_busy);
      chk("psel",       psel,       m_busy);
      chk("penable",    penable,    m_busy && m_access);
      chk("pwrite",     pwrite,     m_write);
      chk("paddr",      paddr,      m_addr);
      chk("pwdata",     pwdata,     m_wdata);
      chk("rsp_valid",  rsp_valid,  m_rsp);
      chk("rsp_rdata",  rsp_rdata,  m_rdata);
      chk("rsp_slverr", rsp_slverr, m_err);
    end
  end

  // Completer: comp_waits stalled ACCESS cycles (-1 = never ready), junk on the bus otherwise.
  int            comp_waits = 0;
  int            w_cnt = 0;
  bit            comp_rand = 0;
  bit            comp_err = 0;
  logic [DW-1:0] comp_rdata = '0;

  always @(posedge pclk) begin
    #2;
    if (psel && penable) begin
      if (comp_rand) begin
        pready  = 1'($urandom_range(0, 1));
        prdata  = DW'($urandom);
        pslverr = ($urandom_range(0, 3) == 0);
      end else if (comp_waits < 0 || w_cnt < comp_waits) begin
        w_cnt++;
        pready  = 1'b0;
        prdata  = DW'($urandom);
        pslverr = 1'($urandom_range(0, 1));
      end else begin
        pready  = 1'b1;
        prdata  = comp_rdata;
        pslverr = comp_err;
      end
    end else begin
      w_cnt   = 0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = DW'($urandom);
      pslverr = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    bit rdy;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = cmd_ready;
      tick();
      ok = rdy;
    end
    cmd_valid = 1'b0;
    chk("accept_seen", ok, 1);
  endtask

  // lat counts from the accept edge's cycle through the cycle carrying rsp_valid.
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output int n_access);
    bit ok;
    int acc;
    lat = -1;
    n_access = 0;
    issue(w, a, d, ok);
    acc = cyc;
    if (ok) begin
      for (int i = 0; i < 200; i++) begin
        if (rsp_valid) begin
          lat = cyc - acc + 1;
          break;
        end
        if (penable) n_access++;
        tick();
      end
      if (lat < 0) chk("rsp_seen", rsp_valid, 1);
    end
  endtask

  initial begin
    int lat, nacc, nrsp, nsetup, hold;
    int rsp_cyc[3];
    bit rdy, ok;

    repeat (3) tick();
    preset = 1'b0;
    chk("reset_ctrl", {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_slverr}, 6'b100000);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rdata", rsp_rdata, 0);

    comp_waits = 0; comp_err = 0;
    xfer(1'b1, 10'h005, 32'hDEADBEEF, lat, nacc);
    chk("wr_latency", lat, 3);
    chk("wr_access_cycles", nacc, 1);
    chk("wr_bus", {pwrite, paddr, pwdata}, {1'b1, 10'h005, 32'hDEADBEEF});
    chk("wr_rsp", {rsp_slverr, rsp_rdata}, {1'b0, 32'h0});

    comp_waits = 2; comp_rdata = 32'h12345678;
    xfer(1'b0, 10'h3FF, DW'($urandom), lat, nacc);
    chk("rd_latency", lat, 5);
    chk("rd_access_cycles", nacc, 3);
    chk("rd_rdata", rsp_rdata, 32'h12345678);
    chk("rd_bus", {pwrite, paddr}, {1'b0, 10'h3FF});

    comp_waits = 0; comp_err = 1; comp_rdata = 32'hCAFE0001;
    xfer(1'b0, 10'h010, 32'h0, lat, nacc);
    chk("err_slverr", rsp_slverr, 1);
    comp_err = 0; comp_rdata = 32'hA5A50002;
    xfer(1'b0, 10'h011, 32'h0, lat, nacc);
    chk("clean_slverr", rsp_slverr, 0);
    chk("clean_rdata", rsp_rdata, 32'hA5A50002);

    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h001; cmd_wdata = 32'h11110000;
    nacc = 0; nrsp = 0; nsetup = 0;
    for (int i = 0; i < 30 && nrsp < 3; i++) begin
      rdy = cmd_ready;
      tick();
      if (rdy && cmd_valid) begin
        nacc++;
        if (nacc < 3) cmd_addr = AW'(nacc + 1);
        else cmd_valid = 1'b0;
      end
      if (psel && !penable) begin
        nsetup++;
        chk("b2b_setup_addr", paddr, nacc);
      end
      if (rsp_valid) begin
        rsp_cyc[nrsp] = cyc;
        nrsp++;
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_rsp_count", nrsp, 3);
    chk("b2b_setup_count", nsetup, 3);
    if (nrsp == 3) begin
      chk("b2b_gap1", rsp_cyc[1] - rsp_cyc[0], 3);
      chk("b2b_gap2", rsp_cyc[2] - rsp_cyc[1], 3);
    end

    comp_waits = -1;
    issue(1'b0, 10'h0AA, 32'h0, ok);
    hold = 0;
    for (int i = 0; i < 10 && !penable; i++) tick();
    tick();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    chk("midrst_ctrl", {psel, penable, cmd_ready, rsp_valid}, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 0);
    end

`ifdef APB_REQUESTER_TIMEOUT_EN
    xfer(1'b0, 10'h020, 32'h0, lat, nacc);
    chk("tmo_latency", lat, 6);
    chk("tmo_access_cycles", nacc, 4);
    chk("tmo_rsp", {rsp_slverr, rsp_rdata}, {1'b1, 32'h0});
`else
    issue(1'b0, 10'h020, 32'h0, ok);
    tick();
    for (int i = 0; i < 120; i++) begin
      tick();
      if (penable && !rsp_valid) hold++;
    end
    chk("no_tmo_hold", hold, 120);
    preset = 1'b1;
    tick();
    preset = 1'b0;
`endif
    comp_waits = 0;

    comp_rand = 1;
    for (int i = 0; i < 600; i++) begin
      rdy = cmd_ready;
      tick();
      if (!cmd_valid || rdy || preset) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
      end
      preset = ($urandom_range(0, 99) == 0);
    end
    comp_rand = 0;
    cmd_valid = 1'b0;
    preset = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
